// File: rtl/vt_ram_arb_if.sv
// Bus bundle around the video RAM arbiter: CPU Wishbone master port, video fetch port, RAM slave port.
// "slave" is the arbiter's view; "master" is the surrounding system (CPU, fetcher, RAM).
interface vt_ram_arb_if #(
  parameter int AW = 16
);
  logic [AW-1:0] cpu_adr_i;
  logic [15:0]   cpu_dat_i;
  logic [15:0]   cpu_dat_o;
  logic          cpu_cyc_i;
  logic          cpu_stb_i;
  logic          cpu_we_i;
  logic [1:0]    cpu_sel_i;
  logic          cpu_ack_o;

  logic          vid_req_i;
  logic [AW-1:0] vid_adr_i;
  logic [15:0]   vid_dat_o;
  logic          vid_ack_o;

  logic [AW-1:0] s_adr_o;
  logic [15:0]   s_dat_o;
  logic [15:0]   s_dat_i;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic          s_we_o;
  logic [1:0]    s_sel_o;
  logic          s_ack_i;

  modport slave (
    input  cpu_adr_i, cpu_dat_i, cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i,
    output cpu_dat_o, cpu_ack_o,
    input  vid_req_i, vid_adr_i,
    output vid_dat_o, vid_ack_o,
    output s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output cpu_adr_i, cpu_dat_i, cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i,
    input  cpu_dat_o, cpu_ack_o,
    output vid_req_i, vid_adr_i,
    input  vid_dat_o, vid_ack_o,
    input  s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/vt_ram_arb.sv
// Shares the video RAM slave between CPU (r/w) and video fetcher (read-only); video has priority
// up to VID_BURST grants while the CPU waits. Each transfer returns to IDLE so the RAM's cyc drops.
module vt_ram_arb #(
  parameter int AW        = 16,
  parameter int VID_BURST = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n,
  vt_ram_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_VID  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(VID_BURST);

  state_t      state_q, state_d;
  logic [3:0]  vcnt_q, vcnt_d;
  logic        vid_ack_q, vid_ack_d;
  logic [15:0] vid_dat_q, vid_dat_d;

  logic cpu_pend;
  logic burst_hit;

  assign cpu_pend  = bus.cpu_cyc_i & bus.cpu_stb_i;
  assign burst_hit = (vcnt_q == BURST_MAX);

  always_comb begin
    state_d   = state_q;
    vcnt_d    = vcnt_q;
    vid_ack_d = 1'b0;
    vid_dat_d = vid_dat_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_pend && (!bus.vid_req_i || burst_hit)) begin
          state_d = ST_CPU;
          vcnt_d  = 4'd0;
        end else if (bus.vid_req_i) begin
          state_d = ST_VID;
          // Count video wins only while the CPU is actually being held off.
          if (!cpu_pend)                vcnt_d = 4'd0;
          else if (vcnt_q < BURST_MAX)  vcnt_d = vcnt_q + 4'd1;
          else                          vcnt_d = BURST_MAX;
        end else if (!cpu_pend) begin
          vcnt_d = 4'd0;
        end
      end
      ST_CPU: begin
        if (!bus.cpu_cyc_i || bus.s_ack_i) state_d = ST_IDLE;
      end
      ST_VID: begin
        if (bus.s_ack_i) begin
          state_d   = ST_IDLE;
          vid_ack_d = 1'b1;
          vid_dat_d = bus.s_dat_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      vcnt_q    <= 4'd0;
      vid_ack_q <= 1'b0;
      vid_dat_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      vcnt_q    <= vcnt_d;
      vid_ack_q <= vid_ack_d;
      vid_dat_q <= vid_dat_d;
    end
  end

  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = 16'h0000;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = 2'b00;
    case (state_q)
      ST_CPU: begin
        bus.s_adr_o = bus.cpu_adr_i;
        bus.s_dat_o = bus.cpu_dat_i;
        bus.s_cyc_o = bus.cpu_cyc_i;
        bus.s_stb_o = bus.cpu_stb_i;
        bus.s_we_o  = bus.cpu_we_i;
        bus.s_sel_o = bus.cpu_sel_i;
      end
      ST_VID: begin
        bus.s_adr_o = bus.vid_adr_i;
        bus.s_cyc_o = 1'b1;
        bus.s_stb_o = 1'b1;
        bus.s_sel_o = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.cpu_ack_o = (state_q == ST_CPU) & bus.s_ack_i;
  assign bus.cpu_dat_o = bus.s_dat_i;
  assign bus.vid_ack_o = vid_ack_q;
  assign bus.vid_dat_o = vid_dat_q;

endmodule

// File: tb/tb_vt_ram_arb.sv
// Directed bench for vt_ram_arb with a behavioural RAM slave: reads ack on the third cyc&stb cycle,
// writes ack combinationally.
module tb_vt_ram_arb;
  localparam int AW = 16;
  localparam int VB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vt_ram_arb_if #(.AW(AW)) bus();

  vt_ram_arb #(.AW(AW), .VID_BURST(VB)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  // RAM model
  logic [15:0] mem [0:511];
  logic        rd_req, wr_req;
  logic [1:0]  rd_cnt;
  logic        bd_we = 1'b0;
  logic [8:0]  bd_adr = '0;
  logic [15:0] bd_dat = '0;

  assign rd_req      = bus.s_cyc_o & bus.s_stb_o & ~bus.s_we_o;
  assign wr_req      = bus.s_cyc_o & bus.s_stb_o &  bus.s_we_o;
  assign bus.s_ack_i = wr_req | (rd_req & (rd_cnt == 2'd2));
  assign bus.s_dat_i = mem[bus.s_adr_o[9:1]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_cnt <= 2'd0;
    else if (rd_req) rd_cnt <= (rd_cnt == 2'd3) ? 2'd3 : rd_cnt + 2'd1;
    else             rd_cnt <= 2'd0;
  end

  always @(posedge clk) begin
    if (bd_we) mem[bd_adr] <= bd_dat;
    else if (wr_req) begin
      if (bus.s_sel_o[0]) mem[bus.s_adr_o[9:1]][7:0]  <= bus.s_dat_o[7:0];
      if (bus.s_sel_o[1]) mem[bus.s_adr_o[9:1]][15:8] <= bus.s_dat_o[15:8];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [15:0] d);
    next_cycle();
    bd_we = 1'b1; bd_adr = a; bd_dat = d;
    next_cycle();
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.cpu_adr_i = '0; bus.cpu_dat_i = '0; bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0;
    bus.cpu_we_i = 1'b0; bus.cpu_sel_i = 2'b00; bus.vid_req_i = 1'b0; bus.vid_adr_i = '0;
  endtask

  task automatic cpu_start(input logic [15:0] a, input logic we, input logic [1:0] sel, input logic [15:0] d);
    bus.cpu_adr_i = a; bus.cpu_we_i = we; bus.cpu_sel_i = sel; bus.cpu_dat_i = d;
    bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin failures++;
      $display("FAIL reset_s_cyc: got cyc=%b stb=%b want 0/0", bus.s_cyc_o, bus.s_stb_o); end
    checks++; if (bus.cpu_ack_o !== 1'b0 || bus.vid_ack_o !== 1'b0) begin failures++;
      $display("FAIL reset_acks: got cpu=%b vid=%b want 0/0", bus.cpu_ack_o, bus.vid_ack_o); end
    checks++; if (bus.vid_dat_o !== 16'h0000 || bus.s_sel_o !== 2'b00 || bus.s_we_o !== 1'b0) begin failures++;
      $display("FAIL reset_outs: got vid_dat=%h sel=%b we=%b want 0000/00/0", bus.vid_dat_o, bus.s_sel_o, bus.s_we_o); end
    bd_write(9'h008, 16'h1234);
    bd_write(9'h010, 16'h1111);
    bd_write(9'h080, 16'hBEEF);
    @(negedge clk) rst_n = 1'b1;
    // Start a video fetch, then reset it asynchronously mid-transfer.
    next_cycle();
    bus.vid_req_i = 1'b1; bus.vid_adr_i = 16'h0100;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (bus.s_cyc_o !== 1'b1) begin failures++;
      $display("FAIL reset_pre_vid_cyc: got %b want 1", bus.s_cyc_o); end
    #1 rst_n = 1'b0; bus.vid_req_i = 1'b0;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.vid_ack_o !== 1'b0) begin failures++;
      $display("FAIL reset_async: got cyc=%b vid_ack=%b want 0/0", bus.s_cyc_o, bus.vid_ack_o); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (bus.s_cyc_o !== 1'b0 || bus.vid_ack_o !== 1'b0 || bus.cpu_ack_o !== 1'b0) begin failures++;
        $display("FAIL reset_quiet c=%0d: got cyc=%b vid_ack=%b cpu_ack=%b want 000", c, bus.s_cyc_o, bus.vid_ack_o, bus.cpu_ack_o); end
    end
  endtask

  task automatic test_cpu_read();
    next_cycle();
    cpu_start(16'h0010, 1'b0, 2'b11, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.s_cyc_o !== (c >= 1 && c <= 3) || bus.cpu_ack_o !== (c == 3)) begin failures++;
        $display("FAIL cpu_read N+%0d: got cyc=%b ack=%b want %b/%b", c, bus.s_cyc_o, bus.cpu_ack_o, (c >= 1 && c <= 3), (c == 3)); end
      if (c == 3) begin
        checks++; if (bus.cpu_dat_o !== 16'h1234) begin failures++;
          $display("FAIL cpu_read_dat: got %h want 1234", bus.cpu_dat_o); end
      end
      next_cycle();
      if (c == 3) begin bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; end
    end
  endtask

  task automatic test_cpu_write();
    logic [15:0] rd;
    bit          got;
    next_cycle();
    cpu_start(16'h0020, 1'b1, 2'b10, 16'hA55A);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.s_cyc_o !== (c == 1) || bus.cpu_ack_o !== (c == 1)) begin failures++;
        $display("FAIL cpu_write N+%0d: got cyc=%b ack=%b want %b/%b", c, bus.s_cyc_o, bus.cpu_ack_o, (c == 1), (c == 1)); end
      if (c == 1) begin
        checks++; if (bus.s_sel_o !== 2'b10 || bus.s_we_o !== 1'b1 || bus.s_adr_o !== 16'h0020 || bus.s_dat_o !== 16'hA55A) begin failures++;
          $display("FAIL cpu_write_bus: got sel=%b we=%b adr=%h dat=%h want 10/1/0020/a55a", bus.s_sel_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o); end
      end
      next_cycle();
      if (c == 1) begin bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; bus.cpu_we_i = 1'b0; end
    end
    cpu_start(16'h0020, 1'b0, 2'b11, 16'h0000);
    got = 1'b0; rd = '0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.cpu_ack_o === 1'b1) begin got = 1'b1; rd = bus.cpu_dat_o; end
      next_cycle();
    end
    bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0;
    checks++; if (!got || rd !== 16'hA511) begin failures++;
      $display("FAIL cpu_byte_readback: got ack=%b dat=%h want 1/a511", got, rd); end
    next_cycle();
  endtask

  task automatic test_vid_read();
    next_cycle();
    bus.vid_req_i = 1'b1; bus.vid_adr_i = 16'h0100;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (bus.vid_ack_o !== (c == 4) || bus.s_cyc_o !== (c >= 1 && c <= 3)) begin failures++;
        $display("FAIL vid_read N+%0d: got ack=%b cyc=%b want %b/%b", c, bus.vid_ack_o, bus.s_cyc_o, (c == 4), (c >= 1 && c <= 3)); end
      if (bus.s_cyc_o === 1'b1) begin
        checks++; if (bus.s_we_o !== 1'b0 || bus.s_sel_o !== 2'b11 || bus.s_adr_o !== 16'h0100) begin failures++;
          $display("FAIL vid_read_bus: got we=%b sel=%b adr=%h want 0/11/0100", bus.s_we_o, bus.s_sel_o, bus.s_adr_o); end
      end
      if (c == 4) begin
        checks++; if (bus.vid_dat_o !== 16'hBEEF) begin failures++;
          $display("FAIL vid_read_dat: got %h want beef", bus.vid_dat_o); end
      end
      next_cycle();
      if (c == 3) bus.vid_req_i = 1'b0;
    end
  endtask

  task automatic test_contention();
    int vid_before = 0, vid_after = 0, cpu_cnt = 0, drain = 0;
    logic [15:0] cdat = '0;
    bit cpu_seen = 1'b0, drop_cpu;
    next_cycle();
    bus.vid_req_i = 1'b1; bus.vid_adr_i = 16'h0100;
    cpu_start(16'h0010, 1'b0, 2'b11, 16'h0000);
    for (int c = 0; c < 200 && vid_after < 2; c++) begin
      @(negedge clk);
      drop_cpu = 1'b0;
      if (bus.vid_ack_o === 1'b1) begin
        if (cpu_seen) vid_after++; else vid_before++;
      end
      if (bus.cpu_ack_o === 1'b1) begin
        cpu_cnt++; cpu_seen = 1'b1; cdat = bus.cpu_dat_o; drop_cpu = 1'b1;
      end
      next_cycle();
      if (drop_cpu) begin bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; end
    end
    // The last ack cycle already launched another fetch; it must still complete once.
    bus.vid_req_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.vid_ack_o === 1'b1) drain++;
      next_cycle();
    end
    checks++; if (vid_before !== VB) begin failures++;
      $display("FAIL contention_vid_burst: got %0d video grants before cpu want %0d", vid_before, VB); end
    checks++; if (cpu_cnt !== 1 || cdat !== 16'h1234) begin failures++;
      $display("FAIL contention_cpu: got acks=%0d dat=%h want 1/1234", cpu_cnt, cdat); end
    checks++; if (vid_after < 2) begin failures++;
      $display("FAIL contention_vid_resume: got %0d video acks after cpu want >=2", vid_after); end
    checks++; if (drain !== 1) begin failures++;
      $display("FAIL contention_drain: got %0d acks want 1", drain); end
  endtask

  task automatic test_cpu_abort();
    int acks = 0, ack_at = -1;
    next_cycle();
    cpu_start(16'h0010, 1'b0, 2'b11, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.cpu_ack_o !== 1'b0 || bus.s_cyc_o !== (c == 1)) begin failures++;
        $display("FAIL cpu_abort N+%0d: got ack=%b cyc=%b want 0/%b", c, bus.cpu_ack_o, bus.s_cyc_o, (c == 1)); end
      next_cycle();
      if (c == 1) begin bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; end
    end
    bus.vid_req_i = 1'b1; bus.vid_adr_i = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.vid_ack_o === 1'b1) begin acks++; ack_at = c; end
      next_cycle();
      if (c == 3) bus.vid_req_i = 1'b0;
    end
    checks++; if (acks !== 1 || ack_at !== 4) begin failures++;
      $display("FAIL abort_then_vid: got acks=%0d at N+%0d want 1 at N+4", acks, ack_at); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_vid_read();
    test_contention();
    test_cpu_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
